rx_fifo_rd_ctrl: RTL and testbench
==================================

RX_FIFO_RD_CTRL -- requirements
Module: rx_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter MAX_PEND, default 4, meaning depth of the frame-descriptor queue (power of 2, 2..16).
REQ-002 SHALL have parameter LEN_W, default 8, meaning width of the frame length in 64-bit words.
REQ-003 SHALL have port rxclk_180  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rxfifo_empty  in  1  empty flag of the rx data/control FIFO pair.
REQ-006 SHALL have port frame_wr_end  in  1  one-cycle pulse: last word of a frame written into the FIFO.
REQ-007 SHALL have port frame_len  in  LEN_W  word count of that frame, valid with frame_wr_end.
REQ-008 SHALL have port crc_done  in  1  one-cycle pulse: CRC verdict available.
REQ-009 SHALL have port crc_good  in  1  verdict, valid with crc_done; 1 = good.
REQ-010 SHALL have port fifo_rd_en  out  1  read strobe to the FIFO pair.
REQ-011 SHALL have port rx_gate  out  1  high while the current frame's words are to be delivered; low means drain/discard.
REQ-012 SHALL have port rx_good_frame  out  1  one-cycle pulse after the last word of a good frame is read.
REQ-013 SHALL have port rx_bad_frame  out  1  one-cycle pulse after the last word of a bad frame is drained.
REQ-014 SHALL have port frames_pending  out  $clog2(MAX_PEND)+1  number of queued descriptors.
REQ-015 SHALL have port desc_overflow  out  1  sticky: frame_wr_end arrived with queue full.

Function
REQ-016 Each frame_wr_end SHALL push a descriptor {len, checked=0, good=0} into the queue, in order.
REQ-017 Each crc_done SHALL set checked=1 and good=crc_good on the oldest unchecked descriptor; if none exists, it SHALL apply to a descriptor pushed in the same cycle; otherwise it SHALL be ignored.
REQ-018 FSM states IDLE, WAIT_CRC, READ, DONE; encoded 2 bits.
REQ-019 IDLE -> WAIT_CRC when queue non-empty; WAIT_CRC -> READ on the cycle after the head descriptor is checked; READ -> DONE when the remaining-word counter reaches 0 on a read; DONE -> IDLE unconditionally (one cycle).
REQ-020 On entry to READ the counter SHALL load head len; len=0 SHALL go READ -> DONE immediately with no read.
REQ-021 fifo_rd_en SHALL equal (state==READ) & ~rxfifo_empty & (counter!=0), combinationally; counter decrements only on cycles with fifo_rd_en=1.
REQ-022 rx_gate SHALL equal head.good while in READ, else 0; bad frames are still fully read (drained).
REQ-023 In DONE, rx_good_frame or rx_bad_frame (per head.good) SHALL pulse once, registered, and the head descriptor SHALL be popped.
REQ-024 Push when full SHALL be dropped and set desc_overflow; simultaneous push and pop when full SHALL succeed.
REQ-025 frames_pending SHALL reflect pushes/pops with one-cycle latency and never wrap.
REQ-026 First fifo_rd_en for a frame SHALL occur no earlier than 2 cycles after crc_done marks it checked.

Reset
REQ-027 Reset SHALL force state IDLE, queue empty, counter 0, and all outputs 0 (fifo_rd_en, rx_gate, pulses, frames_pending, desc_overflow).
REQ-028 Reset mid-READ SHALL abort the frame without a good/bad pulse; desc_overflow SHALL clear only on reset.

Structure
REQ-029 State encoding and LEN_W default SHALL live in shared package rx_ctrl_pkg.
REQ-030 The descriptor queue SHALL be sub-module rx_desc_queue (push, pop, status-update port, head outputs, count, full, empty).

Verification
REQ-031 frame_wr_end len=3, crc_done good=1 two cycles later, FIFO non-empty -> 3 consecutive fifo_rd_en with rx_gate=1, then one rx_good_frame pulse, frames_pending 1->0.
REQ-032 len=4, crc_good=0 -> 4 fifo_rd_en with rx_gate=0, then one rx_bad_frame pulse.
REQ-033 len=3 good, rxfifo_empty high during 2nd read cycle for 2 cycles -> rd_en gaps for 2 cycles, exactly 3 reads total, one rx_good_frame.
REQ-034 5 frame_wr_end with MAX_PEND=4 and no crc_done -> frames_pending=4, desc_overflow=1, no fifo_rd_en.
REQ-035 frame_wr_end and crc_done in the same cycle on an empty queue -> descriptor marked checked; reads begin 2 cycles later.
REQ-036 reset asserted during READ of len=8 after 3 reads -> all outputs 0 asynchronously, no good/bad pulse, frames_pending=0.

Source files
------------

// File: rtl/rx_ctrl_pkg.sv
// Shared definitions for the rx FIFO read controller: read FSM encoding and
// the default frame-length width.
package rx_ctrl_pkg;

  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CRC = 2'd1,
    ST_READ     = 2'd2,
    ST_DONE     = 2'd3
  } rd_state_e;

endpackage

// File: rtl/rx_fifo_rd_ctrl_if.sv
// Link between the read controller and its frame-descriptor queue.
interface rx_fifo_rd_ctrl_if #(
  parameter int LEN_W = rx_ctrl_pkg::LEN_W_DEF,
  parameter int CNT_W = 3
);
  // push/upd/pop are single-cycle strobes with no ready: the queue silently
  // drops a push when full (unless a pop coincides); full lets the owner flag it.
  logic             push;
  logic [LEN_W-1:0] push_len;
  logic             upd;
  logic             upd_good;
  logic             pop;
  logic [LEN_W-1:0] head_len;
  logic             head_checked;
  logic             head_good;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport master (
    output push, push_len, upd, upd_good, pop,
    input  head_len, head_checked, head_good, count, full, empty
  );

  modport slave (
    input  push, push_len, upd, upd_good, pop,
    output head_len, head_checked, head_good, count, full, empty
  );
endinterface

// File: rtl/rx_desc_queue.sv
// Circular queue of frame descriptors {len, checked, good}; CRC verdicts are
// applied in arrival order to the oldest descriptor still lacking one.
module rx_desc_queue
  import rx_ctrl_pkg::*;
#(
  parameter int MAX_PEND = 4,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  rx_fifo_rd_ctrl_if.slave    q
);

  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = $clog2(MAX_PEND) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PEND);

  logic [LEN_W-1:0]    len_mem [MAX_PEND];
  logic [MAX_PEND-1:0] chk_mem;
  logic [MAX_PEND-1:0] good_mem;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    upd_idx;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    chk_cnt;
  logic                full;
  logic                empty;
  logic                push_ok;
  logic                pop_ok;
  logic                upd_ok;
  logic                pop_chk;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = q.pop & ~empty;
  assign push_ok = q.push & (~full | pop_ok);

  // Verdicts arrive in order, so checked entries form a prefix from rd_ptr;
  // the first unchecked slot (or the slot being pushed now) is rd_ptr+chk_cnt.
  assign upd_ok  = q.upd & ((chk_cnt != count) | push_ok);
  assign upd_idx = rd_ptr + chk_cnt[PTR_W-1:0];
  assign pop_chk = pop_ok & chk_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      chk_cnt  <= '0;
      chk_mem  <= '0;
      good_mem <= '0;
      for (int i = 0; i < MAX_PEND; i++) len_mem[i] <= '0;
    end else begin
      if (push_ok) begin
        len_mem[wr_ptr]  <= q.push_len;
        chk_mem[wr_ptr]  <= 1'b0;
        good_mem[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (upd_ok) begin
        chk_mem[upd_idx]  <= 1'b1;
        good_mem[upd_idx] <= q.upd_good;
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count + {{(CNT_W-1){1'b0}}, push_ok} - {{(CNT_W-1){1'b0}}, pop_ok};
      chk_cnt <= chk_cnt + {{(CNT_W-1){1'b0}}, upd_ok} - {{(CNT_W-1){1'b0}}, pop_chk};
    end
  end

  assign q.head_len     = len_mem[rd_ptr];
  assign q.head_checked = chk_mem[rd_ptr] & ~empty;
  assign q.head_good    = good_mem[rd_ptr];
  assign q.count        = count;
  assign q.full         = full;
  assign q.empty        = empty;

endmodule

// File: rtl/rx_fifo_rd_ctrl.sv
// Reads each queued frame out of the rx FIFO once its CRC verdict is known,
// gating delivery for good frames and draining bad ones.
module rx_fifo_rd_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int MAX_PEND = 4,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                      rxclk_180,
  input  logic                      reset,
  input  logic                      rxfifo_empty,
  input  logic                      frame_wr_end,
  input  logic [LEN_W-1:0]          frame_len,
  input  logic                      crc_done,
  input  logic                      crc_good,
  output logic                      fifo_rd_en,
  output logic                      rx_gate,
  output logic                      rx_good_frame,
  output logic                      rx_bad_frame,
  output logic [$clog2(MAX_PEND):0] frames_pending,
  output logic                      desc_overflow,
  output rd_state_e                 dbg_state
);

  rx_fifo_rd_ctrl_if #(.LEN_W(LEN_W), .CNT_W($clog2(MAX_PEND) + 1)) dq ();

  rx_desc_queue #(.MAX_PEND(MAX_PEND), .LEN_W(LEN_W)) u_queue (
    .clk (rxclk_180),
    .rst (reset),
    .q   (dq.slave)
  );

  rd_state_e        state;
  logic [LEN_W-1:0] remaining;
  logic             good_q;
  logic             bad_q;
  logic             ovf_q;
  logic             in_read;
  logic             frame_end;

  assign dq.push     = frame_wr_end;
  assign dq.push_len = frame_len;
  assign dq.upd      = crc_done;
  assign dq.upd_good = crc_good;
  assign dq.pop      = (state == ST_DONE);

  assign in_read    = (state == ST_READ);
  assign fifo_rd_en = in_read & ~rxfifo_empty & (remaining != '0);
  // A zero-length frame finishes on its first READ cycle without a read.
  assign frame_end  = in_read & ((remaining == '0) |
                                 (fifo_rd_en & (remaining == LEN_W'(1))));

  always_ff @(posedge rxclk_180 or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      good_q <= frame_end & dq.head_good;
      bad_q  <= frame_end & ~dq.head_good;
      if (dq.push & dq.full & ~dq.pop) ovf_q <= 1'b1;
      case (state)
        ST_IDLE: if (!dq.empty) state <= ST_WAIT_CRC;
        ST_WAIT_CRC: begin
          if (dq.head_checked) begin
            state     <= ST_READ;
            remaining <= dq.head_len;
          end
        end
        ST_READ: begin
          if (fifo_rd_en) remaining <= remaining - LEN_W'(1);
          if (frame_end) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx_gate        = in_read & dq.head_good;
  assign rx_good_frame  = good_q;
  assign rx_bad_frame   = bad_q;
  assign frames_pending = dq.count;
  assign desc_overflow  = ovf_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_rx_fifo_rd_ctrl.sv
// Bench for rx_fifo_rd_ctrl: directed scenarios plus random traffic, with a
// frame-level model feeding an expected-output queue checked by a monitor.
module tb_rx_fifo_rd_ctrl;
  import rx_ctrl_pkg::*;

  localparam int MAX_PEND = 4;
  localparam int LEN_W    = 8;
  localparam int CNT_W    = $clog2(MAX_PEND) + 1;

  // ---------------- clock / reset ----------------
  logic             rxclk_180 = 1'b0;
  logic             reset = 1'b1;
  logic             rxfifo_empty = 1'b0;
  logic             frame_wr_end = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             crc_done = 1'b0;
  logic             crc_good = 1'b0;
  logic             fifo_rd_en;
  logic             rx_gate;
  logic             rx_good_frame;
  logic             rx_bad_frame;
  logic [CNT_W-1:0] frames_pending;
  logic             desc_overflow;
  rd_state_e        dbg_state;

  always #5 rxclk_180 = ~rxclk_180;

  int cyc = 0;
  always @(posedge rxclk_180) cyc <= cyc + 1;

  rx_fifo_rd_ctrl #(.MAX_PEND(MAX_PEND), .LEN_W(LEN_W)) dut (
    .rxclk_180      (rxclk_180),
    .reset          (reset),
    .rxfifo_empty   (rxfifo_empty),
    .frame_wr_end   (frame_wr_end),
    .frame_len      (frame_len),
    .crc_done       (crc_done),
    .crc_good       (crc_good),
    .fifo_rd_en     (fifo_rd_en),
    .rx_gate        (rx_gate),
    .rx_good_frame  (rx_good_frame),
    .rx_bad_frame   (rx_bad_frame),
    .frames_pending (frames_pending),
    .desc_overflow  (desc_overflow),
    .dbg_state      (dbg_state)
  );

  // ---------------- model / scoreboard state ----------------
  // exp_q entries: {1'b0, gate} for one read word, {1'b1, good} for the end pulse.
  logic [1:0] exp_q[$];
  int         crc_cyc_q[$];
  int         unchk_q[$];
  int         rd_log[$];
  int         model_out = 0;
  bit         exp_ovf = 1'b0;
  bit         in_frame = 1'b0;
  int         last_lat = -1;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One call = one clock cycle of input values; the model is updated with the
  // frame-level consequences of what was driven.
  task automatic step(input bit wr, input int len, input bit crc, input bit good, input bit emp);
    int l;
    @(posedge rxclk_180);
    #2;
    frame_wr_end = wr;
    frame_len    = len[LEN_W-1:0];
    crc_done     = crc;
    crc_good     = good;
    rxfifo_empty = emp;
    if (wr) begin
      if (model_out < MAX_PEND) begin
        unchk_q.push_back(len);
        model_out++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (crc && unchk_q.size() > 0) begin
      l = unchk_q.pop_front();
      for (int i = 0; i < l; i++) exp_q.push_back({1'b0, good});
      exp_q.push_back({1'b1, good});
      crc_cyc_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || model_out > 0) && n < budget) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    idle(2);
    check(name, (exp_q.size() == 0 && model_out == 0), 1);
  endtask

  task automatic wait_reads(input int want, input int budget);
    int n = 0;
    while (rd_log.size() < want && n < budget) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
  endtask

  // ---------------- monitor ----------------
  task automatic run_monitor();
    logic [1:0] e;
    forever begin
      @(negedge rxclk_180);
      if (reset) begin
        in_frame = 1'b0;
      end else begin
        if (fifo_rd_en) begin
          rd_log.push_back(cyc);
          if (!in_frame) begin
            in_frame = 1'b1;
            if (crc_cyc_q.size() > 0) begin
              last_lat = cyc - crc_cyc_q[0];
              check("crc_to_first_read_ge2", (last_lat >= 2), 1);
            end
          end
          if (exp_q.size() == 0) begin
            check("unexpected_read", 32'(fifo_rd_en), 0);
          end else begin
            e = exp_q.pop_front();
            check("read_vs_expected", {30'd0, 1'b0, rx_gate}, {30'd0, e});
          end
        end
        if (rx_good_frame || rx_bad_frame) begin
          check("pulse_exclusive", 32'(rx_good_frame & rx_bad_frame), 0);
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(rx_good_frame | rx_bad_frame), 0);
          end else begin
            e = exp_q.pop_front();
            check("pulse_vs_expected", {30'd0, 1'b1, rx_good_frame}, {30'd0, e});
          end
          if (crc_cyc_q.size() > 0) void'(crc_cyc_q.pop_front());
          if (model_out > 0) model_out--;
        end
      end
    end
  endtask

  // ---------------- stimulus sequence ----------------
  task automatic main_seq();
    int c;
    bit wr;
    repeat (2) @(negedge rxclk_180);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_gate", 32'(rx_gate), 0);
    check("rst_good", 32'(rx_good_frame), 0);
    check("rst_bad", 32'(rx_bad_frame), 0);
    check("rst_pending", 32'(frames_pending), 0);
    check("rst_overflow", 32'(desc_overflow), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge rxclk_180);
    #2;
    reset = 1'b0;
    idle(2);

    // Good frame of 3 words, verdict two cycles after the write end.
    rd_log.delete(); last_lat = -1;
    step(1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    wait_reads(1, 20);
    check("good3_latency", last_lat, 2);
    check("good3_pending_during", 32'(frames_pending), 1);
    wait_drain("good3_drain", 60);
    check("good3_reads", rd_log.size(), 3);
    if (rd_log.size() == 3) check("good3_back_to_back", rd_log[2] - rd_log[0], 2);
    check("good3_pending_after", 32'(frames_pending), 0);

    // Bad frame of 4 words is drained with the gate low.
    rd_log.delete();
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    wait_drain("bad4_drain", 60);
    check("bad4_reads", rd_log.size(), 4);

    // FIFO empty for two cycles at the second read slot.
    rd_log.delete();
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    c = cyc;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    wait_drain("stall_drain", 60);
    check("stall_reads", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      check("stall_read0_cycle", rd_log[0], c + 2);
      check("stall_read1_cycle", rd_log[1], c + 5);
      check("stall_read2_cycle", rd_log[2], c + 6);
    end

    // Write end and verdict together on an empty queue.
    rd_log.delete(); last_lat = -1;
    step(1, 2, 1, 1, 0);
    wait_drain("same_cycle_drain", 60);
    check("same_cycle_reads", rd_log.size(), 2);
    check("same_cycle_latency", (last_lat >= 2 && last_lat <= 3), 1);

    // Five write ends with no verdicts: one dropped, sticky overflow.
    rd_log.delete();
    repeat (5) step(1, 2, 0, 0, 0);
    idle(3);
    check("ovf_pending", 32'(frames_pending), MAX_PEND);
    check("ovf_flag", 32'(desc_overflow), 32'(exp_ovf));
    check("ovf_no_reads", rd_log.size(), 0);
    repeat (4) step(0, 0, 1, $urandom_range(0, 1), 0);
    step(0, 0, 1, 1, 0);
    wait_drain("ovf_drain", 100);
    check("ovf_reads", rd_log.size(), 8);
    check("ovf_sticky", 32'(desc_overflow), 1);

    // Reset in the middle of an 8-word read.
    rd_log.delete();
    step(1, 8, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    wait_reads(3, 20);
    check("rstmid_reads_before", rd_log.size(), 3);
    reset = 1'b1;
    #1;
    check("rstmid_rd_en", 32'(fifo_rd_en), 0);
    check("rstmid_gate", 32'(rx_gate), 0);
    check("rstmid_pulses", 32'(rx_good_frame | rx_bad_frame), 0);
    check("rstmid_pending", 32'(frames_pending), 0);
    check("rstmid_overflow", 32'(desc_overflow), 0);
    exp_q.delete(); crc_cyc_q.delete(); unchk_q.delete();
    model_out = 0; exp_ovf = 1'b0;
    idle(2);
    @(posedge rxclk_180);
    #2;
    reset = 1'b0;
    rd_log.delete();
    idle(10);
    check("rstmid_quiet_after", rd_log.size(), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      wr = (model_out < MAX_PEND) && ($urandom_range(0, 3) == 0);
      step(wr, $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
    end
    while (unchk_q.size() > 0) step(0, 0, 1, $urandom_range(0, 1), 0);
    wait_drain("random_drain", 600);
    check("random_pending_end", 32'(frames_pending), 0);
    check("random_overflow_end", 32'(desc_overflow), 32'(exp_ovf));
    check("scoreboard_empty_end", exp_q.size(), 0);
  endtask

  // ---------------- run + report ----------------
  initial begin
    fork
      run_monitor();
      main_seq();
      begin
        repeat (60000) @(posedge rxclk_180);
        checks++;
        failures++;
        $display("FAIL global_timeout actual=expired required=finished");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
